hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight writers in EX/MEM/WB and raises
// stall, flush and bubble for load-use/RAW interlocks and taken branches.
module hazard_ctrl #(
    parameter int unsigned REG_SEL      = 5,
    parameter int unsigned FWD          = 1,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [REG_SEL-1:0] id_rs1,
    input  logic [REG_SEL-1:0] id_rs2,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic [REG_SEL-1:0] id_destination,
    input  logic               id_write_reg,
    input  logic               id_mem_read,
    input  logic               ex_branch_taken,
    output logic               stall,
    output logic               flush,
    output logic               bubble,
    output logic [1:0]         state,
    output logic [15:0]        stall_count
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } state_e;

    localparam logic [2:0] CntInit = 3'(FLUSH_CYCLES - 1);

    state_e                    state_q, state_d;
    logic   [2:0]              cnt_q, cnt_d;
    logic   [15:0]             stall_count_q;
    // Slot index 0 = EX, 1 = MEM, 2 = WB.
    logic   [2:0]              slot_valid_q;
    logic   [2:0]              slot_load_q;
    logic   [2:0][REG_SEL-1:0] slot_rd_q;
    logic                      hazard;
    logic                      ex_load;

    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (slot_valid_q[k] && (FWD == 0 || (k == 0 && slot_load_q[0]))) begin
                if (id_uses_rs1 && id_rs1 != '0 && id_rs1 == slot_rd_q[k]) hazard = 1'b1;
                if (id_uses_rs2 && id_rs2 != '0 && id_rs2 == slot_rd_q[k]) hazard = 1'b1;
            end
        end
    end

    // Branch outranks everything; FLUSH ignores hazards until the counter expires.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        flush   = 1'b0;
        bubble  = 1'b0;
        if (ex_branch_taken) begin
            flush   = 1'b1;
            bubble  = 1'b1;
            state_d = StFlush;
            cnt_d   = CntInit;
        end else if (state_q == StFlush) begin
            flush  = 1'b1;
            bubble = 1'b1;
            if (cnt_q == 3'd0) begin
                state_d = StRun;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end else if (id_valid && hazard) begin
            stall   = 1'b1;
            bubble  = 1'b1;
            state_d = StStall;
        end else begin
            state_d = StRun;
        end
    end

    assign ex_load = id_valid && id_write_reg && !bubble && (id_destination != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StRun;
            cnt_q         <= 3'd0;
            stall_count_q <= 16'd0;
            slot_valid_q  <= 3'b000;
            slot_load_q   <= 3'b000;
            slot_rd_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slot_valid_q <= {slot_valid_q[1:0], ex_load};
            slot_load_q  <= {slot_load_q[1:0], id_mem_read};
            slot_rd_q    <= {slot_rd_q[1:0], id_destination};
            if (stall && stall_count_q != 16'hFFFF) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
        end
    end

    assign state       = state_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl: two instances (FWD=1, FWD=0) checked
// every cycle against a scoreboard fed by an in-bench pipeline model.
`timescale 1ns/1ps
module tb_hazard_ctrl;

    localparam int FC = 2;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] dst;
        logic       wr;
        logic       ld;
        logic       br;
    } stim_t;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        bubble;
        logic [1:0]  state;
        logic [15:0] count;
    } exp_t;

    // Abstract model: rd[0..2] = destinations written 1..3 instructions ago (0 = none).
    typedef struct {
        int rd[3];
        bit ld[3];
        int flush_left;
        bit stalled;
        int sc;
    } model_t;

    logic        clk = 1'b0;
    logic        rst_l[2];
    stim_t       drv[2];
    logic        d_stall[2], d_flush[2], d_bubble[2];
    logic [1:0]  d_state[2];
    logic [15:0] d_count[2];

    model_t m[2];
    stim_t  s_cur[2];
    exp_t   e_cur[2];
    exp_t   q0[$];
    exp_t   q1[$];
    int     checks = 0;
    int     failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_SEL(5), .FWD(1), .FLUSH_CYCLES(FC)) dut0 (
        .clk(clk), .rst(rst_l[0]), .id_valid(drv[0].valid),
        .id_rs1(drv[0].rs1), .id_rs2(drv[0].rs2),
        .id_uses_rs1(drv[0].u1), .id_uses_rs2(drv[0].u2),
        .id_destination(drv[0].dst), .id_write_reg(drv[0].wr),
        .id_mem_read(drv[0].ld), .ex_branch_taken(drv[0].br),
        .stall(d_stall[0]), .flush(d_flush[0]), .bubble(d_bubble[0]),
        .state(d_state[0]), .stall_count(d_count[0])
    );

    hazard_ctrl #(.REG_SEL(5), .FWD(0), .FLUSH_CYCLES(FC)) dut1 (
        .clk(clk), .rst(rst_l[1]), .id_valid(drv[1].valid),
        .id_rs1(drv[1].rs1), .id_rs2(drv[1].rs2),
        .id_uses_rs1(drv[1].u1), .id_uses_rs2(drv[1].u2),
        .id_destination(drv[1].dst), .id_write_reg(drv[1].wr),
        .id_mem_read(drv[1].ld), .ex_branch_taken(drv[1].br),
        .stall(d_stall[1]), .flush(d_flush[1]), .bubble(d_bubble[1]),
        .state(d_state[1]), .stall_count(d_count[1])
    );

    function automatic model_t model_reset();
        model_t r;
        for (int k = 0; k < 3; k++) begin
            r.rd[k] = 0;
            r.ld[k] = 1'b0;
        end
        r.flush_left = 0;
        r.stalled    = 1'b0;
        r.sc         = 0;
        return r;
    endfunction

    function automatic exp_t model_out(input model_t mm, input stim_t s, input int fwd);
        exp_t e;
        bit   haz;
        bit   reach;
        haz = 1'b0;
        for (int k = 0; k < 3; k++) begin
            reach = (fwd != 0) ? (k == 0 && mm.ld[k]) : 1'b1;
            if (mm.rd[k] != 0 && reach &&
                ((s.u1 && int'(s.rs1) == mm.rd[k]) || (s.u2 && int'(s.rs2) == mm.rd[k])))
                haz = 1'b1;
        end
        e = '0;
        if (s.br) begin
            e.flush  = 1'b1;
            e.bubble = 1'b1;
        end else if (mm.flush_left > 0) begin
            e.flush  = 1'b1;
            e.bubble = 1'b1;
        end else if (s.valid && haz) begin
            e.stall  = 1'b1;
            e.bubble = 1'b1;
        end
        e.state = (mm.flush_left > 0) ? 2'd2 : (mm.stalled ? 2'd1 : 2'd0);
        e.count = 16'(mm.sc);
        return e;
    endfunction

    function automatic model_t model_step(input model_t mm, input stim_t s, input exp_t e);
        model_t r;
        r = mm;
        r.rd[2] = mm.rd[1];
        r.ld[2] = mm.ld[1];
        r.rd[1] = mm.rd[0];
        r.ld[1] = mm.ld[0];
        r.rd[0] = (s.valid && s.wr && !e.bubble) ? int'(s.dst) : 0;
        r.ld[0] = s.ld;
        if (s.br) r.flush_left = FC;
        else if (mm.flush_left > 0) r.flush_left = mm.flush_left - 1;
        r.stalled = e.stall;
        if (e.stall && mm.sc < 65535) r.sc = mm.sc + 1;
        return r;
    endfunction

    function automatic stim_t mk(bit v, int r1, bit u1, int r2, bit u2, int d, bit w, bit l,
                                 bit b);
        stim_t s;
        s.valid = v;
        s.rs1   = 5'(r1);
        s.u1    = u1;
        s.rs2   = 5'(r2);
        s.u2    = u2;
        s.dst   = 5'(d);
        s.wr    = w;
        s.ld    = l;
        s.br    = b;
        return s;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive_cycle(input int i, input stim_t ns, input bit rst_lo);
        stim_t sv;
        sv = ns;
        @(posedge clk);
        if (rst_l[i]) m[i] = model_step(m[i], s_cur[i], e_cur[i]);
        #1;
        if (rst_lo) begin
            rst_l[i] = 1'b0;
            m[i]     = model_reset();
            sv       = '0;
        end else begin
            rst_l[i] = 1'b1;
        end
        drv[i]   = sv;
        s_cur[i] = sv;
        e_cur[i] = model_out(m[i], sv, (i == 0) ? 1 : 0);
        if (i == 0) q0.push_back(e_cur[i]);
        else q1.push_back(e_cur[i]);
    endtask

    // Hold an instruction in ID until the model says it is no longer stalled.
    task automatic issue(input int i, input stim_t ins);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 8 && !done; n++) begin
            drive_cycle(i, ins, 1'b0);
            if (!e_cur[i].stall) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: inst %0d still stalled after 8 cycles", i);
        end
    endtask

    task automatic rand_cycles(input int i, input int n);
        stim_t s;
        for (int c = 0; c < n; c++) begin
            s.valid = ($urandom % 4) != 0;
            s.rs1   = 5'($urandom % 6);
            s.u1    = 1'($urandom);
            s.rs2   = 5'($urandom % 6);
            s.u2    = 1'($urandom);
            s.dst   = 5'($urandom % 6);
            s.wr    = 1'($urandom);
            s.ld    = 1'($urandom);
            s.br    = ($urandom % 12) == 0;
            drive_cycle(i, s, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        for (int i = 0; i < 2; i++) begin
            if ((i == 0 && q0.size() != 0) || (i == 1 && q1.size() != 0)) begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                g = {d_stall[i], d_flush[i], d_bubble[i], d_state[i], d_count[i]};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL sb%0d @%0t: got s/f/b=%b%b%b st=%0d cnt=%0d expected s/f/b=%b%b%b st=%0d cnt=%0d",
                             i, $time, g.stall, g.flush, g.bubble, g.state, g.count,
                             e.stall, e.flush, e.bubble, e.state, e.count);
                end
            end
        end
    end

    task automatic seq_fwd();
        stim_t idle, lw5, add6, add5, sub7, lw0, add1, addi6;
        idle  = '0;
        lw5   = mk(1, 1, 1, 0, 0, 5, 1, 1, 0);
        add6  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0);
        add5  = mk(1, 1, 1, 2, 1, 5, 1, 0, 0);
        sub7  = mk(1, 5, 1, 2, 1, 7, 1, 0, 0);
        lw0   = mk(1, 1, 1, 0, 0, 0, 1, 1, 0);
        add1  = mk(1, 0, 1, 0, 1, 1, 1, 0, 0);
        addi6 = mk(1, 0, 1, 5, 0, 6, 1, 0, 0);
        drive_cycle(0, idle, 1);
        drive_cycle(0, idle, 1);
        @(negedge clk);
        chk("rst_state", int'(d_state[0]), 0);
        chk("rst_count", int'(d_count[0]), 0);
        chk("rst_bubble", int'(d_bubble[0]), 0);
        drive_cycle(0, idle, 0);
        issue(0, lw5);
        issue(0, add6);
        @(negedge clk);
        chk("loaduse_count", int'(d_count[0]), 1);
        repeat (3) drive_cycle(0, idle, 0);
        issue(0, add5);
        issue(0, sub7);
        @(negedge clk);
        chk("aluuse_fwd_count", int'(d_count[0]), 1);
        issue(0, lw0);
        issue(0, add1);
        issue(0, lw5);
        issue(0, addi6);
        @(negedge clk);
        chk("x0_unused_count", int'(d_count[0]), 1);
        repeat (3) drive_cycle(0, idle, 0);
        issue(0, lw5);
        add6.br = 1'b1;
        drive_cycle(0, add6, 0);
        add6.br = 1'b0;
        @(negedge clk);
        chk("br_stall", int'(d_stall[0]), 0);
        chk("br_flush", int'(d_flush[0]), 1);
        drive_cycle(0, idle, 0);
        @(negedge clk);
        chk("br_f1_state", int'(d_state[0]), 2);
        drive_cycle(0, idle, 0);
        @(negedge clk);
        chk("br_f2_flush", int'(d_flush[0]), 1);
        drive_cycle(0, idle, 0);
        @(negedge clk);
        chk("br_end_flush", int'(d_flush[0]), 0);
        chk("br_end_state", int'(d_state[0]), 0);
        drive_cycle(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 0);
        drive_cycle(0, idle, 0);
        drive_cycle(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 0);
        drive_cycle(0, idle, 0);
        drive_cycle(0, idle, 0);
        @(negedge clk);
        chk("rebr_ext_flush", int'(d_flush[0]), 1);
        chk("rebr_ext_state", int'(d_state[0]), 2);
        drive_cycle(0, idle, 0);
        @(negedge clk);
        chk("rebr_end_flush", int'(d_flush[0]), 0);
        issue(0, lw5);
        drive_cycle(0, add6, 0);
        @(negedge clk);
        chk("midstall_stall", int'(d_stall[0]), 1);
        drive_cycle(0, add6, 1);
        @(negedge clk);
        chk("rststall_stall", int'(d_stall[0]), 0);
        chk("rststall_count", int'(d_count[0]), 0);
        drive_cycle(0, idle, 0);
        drive_cycle(0, add6, 0);
        @(negedge clk);
        chk("post_rst_stall", int'(d_stall[0]), 0);
        drive_cycle(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 0);
        drive_cycle(0, idle, 1);
        @(negedge clk);
        chk("rstflush_flush", int'(d_flush[0]), 0);
        drive_cycle(0, idle, 0);
        drive_cycle(0, idle, 0);
        @(negedge clk);
        chk("post_rstflush_state", int'(d_state[0]), 0);
        rand_cycles(0, 1000);
    endtask

    task automatic seq_nofwd();
        stim_t idle, add5, sub7, acc5;
        idle = '0;
        add5 = mk(1, 1, 1, 2, 1, 5, 1, 0, 0);
        sub7 = mk(1, 5, 1, 2, 1, 7, 1, 0, 0);
        acc5 = mk(1, 5, 1, 0, 1, 5, 1, 0, 0);
        drive_cycle(1, idle, 1);
        drive_cycle(1, idle, 1);
        drive_cycle(1, idle, 0);
        issue(1, add5);
        issue(1, sub7);
        @(negedge clk);
        chk("aluuse_nofwd_count", int'(d_count[1]), 3);
        rand_cycles(1, 800);
        drive_cycle(1, idle, 1);
        drive_cycle(1, idle, 0);
        // Each dependent ADD x5,x5,x0 interlocks for 3 cycles: 21850 issues > 65535 stalls.
        for (int n = 0; n < 21850; n++) issue(1, acc5);
        @(negedge clk);
        chk("sat_count", int'(d_count[1]), 65535);
    endtask

    initial begin
        rst_l[0] = 1'b0;
        rst_l[1] = 1'b0;
        drv[0]   = '0;
        drv[1]   = '0;
        s_cur[0] = '0;
        s_cur[1] = '0;
        m[0]     = model_reset();
        m[1]     = model_reset();
        e_cur[0] = '0;
        e_cur[1] = '0;
        fork
            seq_fwd();
            seq_nofwd();
        join
        @(negedge clk);
        @(negedge clk);
        chk("sb_drain0", q0.size(), 0);
        chk("sb_drain1", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
